uart_tx_arb: RTL
================

# uart_tx_arb

Packet-atomic round-robin arbiter that shares the single transmit path of `uart_full` between N byte-stream requesters. It drives `uart_full`'s `i_wr_uart`/`i_wr_data` and honours `o_tx_full`. A granted requester keeps the transmitter until its `last` byte is accepted, so packets from different sources never interleave on `o_tx`. A watchdog reclaims the grant if a requester stalls mid-packet.

## Interface
- `N`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width; matches `uart_full` `i_wr_data`.
- `TIMEOUT`, 1024: idle cycles mid-packet before the grant is revoked, ≥2.
- `i_clk` in 1: system clock. One clock only.
- `i_reset` in 1: synchronous, active-low reset.
- `i_req_valid` in N: requester k has a byte available.
- `i_req_data` in N*DATA_W: requester k byte at bits [k*DATA_W +: DATA_W].
- `i_req_last` in N: byte is the final byte of the packet.
- `o_req_ready` out N: one-hot; the byte of requester k is consumed this cycle when valid & ready.
- `o_grant` out N: one-hot owner of the transmitter, 0 when idle.
- `i_tx_full` in 1: from `uart_full` `o_tx_full`.
- `o_wr_uart` out 1: write strobe to `uart_full` `i_wr_uart`.
- `o_wr_data` out DATA_W: to `uart_full` `i_wr_data`.
- `o_abort` out 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- States:
  - IDLE: no owner.
  - XFER: `o_grant` one-hot, bytes forwarded.
- IDLE → XFER: if any `i_req_valid` is set, grant the first valid index at or after `rr_ptr`, searching upward with wrap from N-1 to 0. The grant is registered.
- In XFER with owner g:
  - `o_req_ready[g] = !i_tx_full`.
  - `o_wr_uart = i_req_valid[g] & !i_tx_full`.
  - `o_wr_data = i_req_data[g]`.
  - Both strobes are combinational, so no write ever occurs while full.
- An accepted byte with `i_req_last[g]=1` → IDLE, and `rr_ptr` = (g+1) mod N.
- Watchdog:
  - Counts XFER cycles with `i_req_valid[g]=0`.
  - Clears on any accepted byte.
  - Does not count while `i_tx_full=1` (a backpressure stall is not a fault).
  - On reaching TIMEOUT: → IDLE, pulse `o_abort`, `rr_ptr` = (g+1) mod N.
- Non-owners always see `o_req_ready=0`. Their `valid` is held and not dropped.
- Outputs of non-owners and all data are don't-care when idle, but `o_wr_data` = 0 in IDLE.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `o_grant` 0, `o_req_ready` 0, `o_wr_uart` 0, `o_wr_data` 0, `o_abort` 0, watchdog 0.
- Request latency:
  - `valid` first seen in IDLE at cycle t → `o_grant` at t+1.
  - The first byte is written at t+1 if `!i_tx_full`.
- Throughput: one byte per cycle while `!i_tx_full`.
- Back-to-back packets:
  - Last byte accepted at cycle k → IDLE at k+1 (arbitration cycle).
  - The next grant is at k+2. This one bubble cycle is required.
- A single-byte packet (`valid` & `last` together) is legal: a 2-cycle grant-plus-return, with 1 write.
- Simultaneous watchdog expiry and byte acceptance on the same cycle: acceptance wins, and the watchdog clears.
- `o_abort` asserts in the cycle the state returns to IDLE, for exactly 1 cycle.
- A reset mid-packet (`i_reset=0`) returns to the reset values on the next edge. A partially sent packet is not resumed.
- `i_tx_full` rising mid-packet: ready drops the same cycle and the grant is kept.

## Structure
- Shared package/header: state encoding (IDLE=0, XFER=1) and the default `TIMEOUT`.
- One natural sub-module: `rr_pick`, a combinational round-robin priority encoder (inputs: request vector and pointer; outputs: one-hot grant and grant index). It is reusable for future RX-side or SPI arbiters.
- Top-level `uart_tx_arb` holds the FSM, `rr_ptr`, owner index, watchdog counter (width clog2(TIMEOUT+1)), and output muxing.

## Test plan
- Reset, then requester 2 sends the 3-byte packet 0x41, 0x42, 0x43 with `last` on 0x43, `i_tx_full=0`:
  - `o_grant`=4'b0100 one cycle after `valid`.
  - 3 consecutive `o_wr_uart` with data 41, 42, 43.
  - IDLE follows, and `rr_ptr`=3.
- All 4 requesters hold 2-byte packets from reset:
  - Grant order is 0, 1, 2, 3.
  - There is exactly one idle bubble between packets.
  - No bytes interleave.
- Requester 1 granted, `i_tx_full` high for 5 cycles mid-packet:
  - `o_req_ready`=0 and `o_wr_uart`=0 during those cycles.
  - The grant is held and `o_abort` never pulses.
  - Transfer resumes the cycle `full` drops.
- Requester 0 sends 1 byte without `last`, then drops `valid` (TIMEOUT=16):
  - `o_abort` pulses 16 cycles later.
  - The grant moves to the waiting requester 3 on the following cycle.
- Single-byte packets from requesters 1 and 3 asserted simultaneously with `rr_ptr`=2:
  - Requester 3 is granted first, then requester 1.
  - Each writes 1 byte.
- Reset asserted in the 2nd byte of a 4-byte packet:
  - All outputs are 0 on the next edge.
  - After release, the same requester is re-granted from `rr_ptr`=0 priority.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the packet-atomic UART transmit arbiter:
// FSM state encoding and default parameter values.
package uart_tx_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    localparam int DEFAULT_N       = 4;
    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester bundle plus the uart_full write port of the arbiter.
// The slave modport is the arbiter; master is whatever drives the requests.
interface uart_tx_arb_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8
);
    logic [N-1:0]        i_req_valid;
    logic [N*DATA_W-1:0] i_req_data;
    logic [N-1:0]        i_req_last;
    logic [N-1:0]        o_req_ready;
    logic [N-1:0]        o_grant;
    logic                i_tx_full;
    logic                o_wr_uart;
    logic [DATA_W-1:0]   o_wr_data;
    logic                o_abort;

    modport master (
        output i_req_valid, i_req_data, i_req_last, i_tx_full,
        input  o_req_ready, o_grant, o_wr_uart, o_wr_data, o_abort
    );

    modport slave (
        input  i_req_valid, i_req_data, i_req_last, i_tx_full,
        output o_req_ready, o_grant, o_wr_uart, o_wr_data, o_abort
    );
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or
// after ptr_i, searching upward with wrap. Reusable for other arbiters.
module rr_pick #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] pos;
    logic             hit;

    // Rotating scan; the first hit latches and masks every later candidate.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        hit   = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos        = IDX_W'((int'(ptr_i) + i) % N);
            hit        = !any_o && req_i[pos];
            gnt_o[pos] = gnt_o[pos] | hit;
            idx_o      = hit ? pos : idx_o;
            any_o      = any_o | hit;
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_full transmit path between N packet
// sources; a grant is held until the last byte or a watchdog revoke.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N       = DEFAULT_N,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         i_clk,
    input  logic         i_reset,
    uart_tx_arb_if.slave bus
);

    localparam int IDX_W = $clog2(N);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic               abort_q, abort_d;

    logic [N-1:0]       pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               in_xfer;
    logic               own_valid;
    logic               own_last;
    logic [DATA_W-1:0]  own_data;
    logic               accept;
    logic [IDX_W-1:0]   next_ptr;

    rr_pick #(.N(N)) u_pick (
        .req_i (bus.i_req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Owner view of the request bus; grant_q is one-hot in XFER so masking selects it.
    always_comb begin
        in_xfer   = (state_q == ST_XFER);
        own_valid = |(bus.i_req_valid & grant_q);
        own_last  = |(bus.i_req_last & grant_q);
        own_data  = '0;
        for (int k = 0; k < N; k++) begin
            own_data = (owner_q == IDX_W'(k)) ? bus.i_req_data[k*DATA_W +: DATA_W] : own_data;
        end
        accept   = in_xfer && own_valid && !bus.i_tx_full;
        next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
    end

    // Strobes stay combinational so a write can never land on a full FIFO.
    assign bus.o_req_ready = (in_xfer && !bus.i_tx_full) ? grant_q : '0;
    assign bus.o_wr_uart   = accept;
    assign bus.o_wr_data   = in_xfer ? own_data : '0;
    assign bus.o_grant     = grant_q;
    assign bus.o_abort     = abort_q;

    // Next-state logic: arbitration in IDLE, packet tracking and watchdog in XFER.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        wd_d     = wd_q;
        abort_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wd_d = '0;
                if (pick_any) begin
                    state_d = ST_XFER;
                    grant_d = pick_gnt;
                    owner_d = pick_idx;
                end else begin
                    grant_d = '0;
                end
            end
            ST_XFER: begin
                if (accept) begin
                    wd_d = '0;
                    if (own_last) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                    end else begin
                        state_d = ST_XFER;
                    end
                end else if (!own_valid && !bus.i_tx_full) begin
                    // Only a silent owner counts; backpressure stalls are not faults.
                    if (wd_q == WD_LIMIT) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        rr_ptr_d = next_ptr;
                        wd_d     = '0;
                        abort_d  = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end else begin
                    wd_d = wd_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                wd_d    = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            wd_q     <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            wd_q     <= wd_d;
            abort_q  <= abort_d;
        end
    end

endmodule
